parity_frame_tx: RTL
====================

Name: parity_frame_tx

Overview:
- Serial frame transmitter placed directly downstream of the even-parity generator.
- Accepts a DATA_W-bit word plus its generated even-parity bit over a valid/ready handshake.
- Serializes them onto a single line as: start bit (0), data bits LSB first, parity bit, stop bit (1).
- Flags words whose supplied parity bit disagrees with the data, so generator faults are visible on the link side.

Parameters:
- DATA_W, 3: width of the data word (matches generator input width); legal range ≥1.
- CLKS_PER_BIT, 4: clock cycles per serial bit; legal range ≥1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- bin  input  DATA_W  data word from upstream.
- pe  input  1  even-parity bit from the generator for bin.
- in_valid  input  1  upstream word and parity are valid.
- in_ready  output  1  block can accept a word this cycle.
- tx  output  1  serial line; idles high.
- busy  output  1  frame in progress (any state other than IDLE).
- frame_done  output  1  one-cycle pulse in the final cycle of the stop bit.
- par_err  output  1  latched on accept; 1 when pe != ^bin. Held until the next accept.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, tx=1, in_ready=1, busy=0, frame_done=0, par_err=0, shift register and counters cleared.
- Reset mid-frame aborts the frame with no frame_done pulse; tx=1 from the following cycle.
- All outputs are registered; in_ready and busy decode the state register.
- States:
  - IDLE: in_ready=1, tx=1.
  - START: tx=0.
  - DATA: tx=shift[0].
  - PARITY: tx=latched pe.
  - STOP: tx=1.
- Accept occurs on a cycle with in_valid && in_ready:
  - Latch bin into the shift register and latch pe.
  - par_err <= (pe != ^bin).
  - Next state is START.
- in_valid while not in IDLE is ignored; upstream must hold bin/pe stable until accepted.
- Every non-IDLE state lasts exactly CLKS_PER_BIT cycles, timed by a tick counter running 0..CLKS_PER_BIT-1.
- DATA runs DATA_W bit periods; the shift register shifts right at the end of each bit period; the bit counter runs 0..DATA_W-1.
- Transitions: START→DATA→PARITY→STOP→IDLE, each at the terminal tick.
- Latency:
  - Accept in cycle N; tx falls in cycle N+1.
  - Frame spans (DATA_W+3)*CLKS_PER_BIT cycles, from N+1 to N+(DATA_W+3)*CLKS_PER_BIT.
  - frame_done is asserted in the last of those cycles.
- Back-to-back: the earliest next accept is the IDLE cycle immediately after frame_done. The line therefore shows at least CLKS_PER_BIT+1 high cycles between frames.
- The transmitted parity bit is always the supplied pe, never recomputed; par_err is purely diagnostic.
- CLKS_PER_BIT=1: tick counter width is max(1, $clog2(CLKS_PER_BIT)); each state lasts one cycle.

Decomposition:
- Shared package parity_link_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP).
  - Constants START_BIT=0 and STOP_BIT=1.
  - Frame-length function (DATA_W+3).
- Sub-module bit_tick_counter (parameter CLKS_PER_BIT):
  - Inputs clk, rst_n, clr, en; output tick at the terminal count.
  - The FSM, shift register and bit counter stay in the top module.

Test Plan:
- Defaults; bin=3'b101, pe=0, in_valid pulsed in cycle N → tx = 0,1,0,1,0,1 for 4 cycles each from N+1; frame_done only at N+24; par_err=0; in_ready=0 over N+1..N+24.
- bin=3'b111, pe=0 (bad parity) → par_err=1 from N+1; parity bit period on tx still 0; frame completes normally; next good word clears par_err.
- in_valid held high with two words queued → second accept in cycle after frame_done; tx high for exactly 5 cycles between frames; no word dropped or duplicated.
- in_valid pulsed mid-frame with different bin → ignored; current frame unchanged; word not accepted.
- rst_n=0 during DATA bit 1 → next cycle tx=1, busy=0, in_ready=1, par_err=0, no frame_done; new accept starts a clean frame.
- CLKS_PER_BIT=1, DATA_W=8; bin=8'hA5, pe=0 → 11-cycle frame: tx = 0, 1,0,1,0,0,1,0,1, 0, 1; frame_done at N+11.

Source files
------------

// File: rtl/parity_link_pkg.sv
// rtl/parity_link_pkg.sv - shared state encoding, line levels and frame sizing for the parity link
package parity_link_pkg;

   typedef logic [2:0] link_state_t;

   localparam link_state_t IDLE   = 3'd0;
   localparam link_state_t START  = 3'd1;
   localparam link_state_t DATA   = 3'd2;
   localparam link_state_t PARITY = 3'd3;
   localparam link_state_t STOP   = 3'd4;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   // Bit periods in one frame: start + data + parity + stop.
   function automatic int frame_bits(input int data_w);
      return data_w + 3;
   endfunction

endpackage

// File: rtl/bit_tick_counter.sv
// rtl/bit_tick_counter.sv - bit-period timer, ticks on the last cycle of each period
module bit_tick_counter
   import parity_link_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4,
   parameter int CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          en,
   output logic          tick,
   output logic [CW-1:0] count
);

   assign tick = en && (count == CW'(CLKS_PER_BIT - 1));

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         count <= '0;
      end else if (en) begin
         count <= tick ? '0 : count + CW'(1);
      end
   end

endmodule

// File: rtl/parity_frame_tx.sv
// rtl/parity_frame_tx.sv - serial frame transmitter: start, data LSB first, supplied parity, stop
module parity_frame_tx
   import parity_link_pkg::*;
#(
   parameter int DATA_W       = 3,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] bin,
   input  logic              pe,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              tx,
   output logic              busy,
   output logic              frame_done,
   output logic              par_err
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   link_state_t       state, state_nxt;
   logic [DATA_W-1:0] shift, shift_nxt;
   logic [BW-1:0]     bit_cnt;
   logic              pe_lat, pe_nxt;
   logic              tx_nxt, done_nxt;
   logic              tick, accept, last_bit;
   logic [CW-1:0]     cnt, cnt_nxt;

   bit_tick_counter #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .CW           (CW)
   ) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (state == IDLE),
      .en    (state != IDLE),
      .tick  (tick),
      .count (cnt)
   );

   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);
   assign accept   = in_valid && in_ready;
   assign last_bit = (bit_cnt == BW'(DATA_W - 1));

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept)              state_nxt = START;
         START:   if (tick)                state_nxt = DATA;
         DATA:    if (tick && last_bit)    state_nxt = PARITY;
         PARITY:  if (tick)                state_nxt = STOP;
         STOP:    if (tick)                state_nxt = IDLE;
         default:                          state_nxt = IDLE;
      endcase
   end

   always_comb begin
      shift_nxt = shift;
      pe_nxt    = pe_lat;
      if (accept) begin
         shift_nxt = bin;
         pe_nxt    = pe;
      end else if (state == DATA && tick) begin
         shift_nxt = shift >> 1;
      end
   end

   // tx and frame_done are registered, so they are derived from next-cycle values.
   assign cnt_nxt = (state == IDLE || tick) ? '0 : cnt + CW'(1);

   always_comb begin
      tx_nxt = STOP_BIT;
      case (state_nxt)
         START:   tx_nxt = START_BIT;
         DATA:    tx_nxt = shift_nxt[0];
         PARITY:  tx_nxt = pe_nxt;
         default: tx_nxt = STOP_BIT;
      endcase
   end

   assign done_nxt = (state_nxt == STOP) && (cnt_nxt == CW'(CLKS_PER_BIT - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         shift      <= '0;
         bit_cnt    <= '0;
         pe_lat     <= 1'b0;
         tx         <= STOP_BIT;
         frame_done <= 1'b0;
         par_err    <= 1'b0;
      end else begin
         state      <= state_nxt;
         shift      <= shift_nxt;
         pe_lat     <= pe_nxt;
         tx         <= tx_nxt;
         frame_done <= done_nxt;
         if (accept) begin
            bit_cnt <= '0;
            par_err <= (pe != ^bin);
         end else if (state == DATA && tick) begin
            bit_cnt <= last_bit ? '0 : bit_cnt + BW'(1);
         end
      end
   end

endmodule
